load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Parametrised load/store engine between the multi-cycle core and a handshaked data bus.
//  Takes one byte/half/word/dword request and drives 1-2 bus beats (misaligned access split
//  across an XLEN boundary). Returns extended load data or a store ack, with error reporting.
// PARAMETERS
//  XLEN             32  data width, 32 or 64; bus beat = XLEN/8 bytes
//  ADDR_WIDTH       32  byte-address width
//  ALLOW_MISALIGNED 1   1: split boundary-crossing access; 0: reject with error, no bus beat
// PORTS
//  clk             in   1        clock, rising edge
//  reset           in   1        asynchronous, active-low reset
//  req_valid       in   1        request present
//  req_ready       out  1        high only in IDLE
//  req_store       in   1        1 store, 0 load
//  req_size        in   2        0 byte, 1 half, 2 word, 3 dword (dword legal only if XLEN=64)
//  req_unsigned    in   1        load zero-extend (else sign-extend)
//  req_address     in   ADDR_W   byte address
//  req_write_data  in   XLEN     store data, LSB-aligned
//  resp_valid      out  1        one-cycle pulse, no backpressure
//  resp_data       out  XLEN     extended load data; 0 for stores and errors
//  resp_error      out  1        valid with resp_valid
//  mem_req         out  1        bus request, held until mem_gnt
//  mem_gnt         in   1        request accepted this cycle
//  mem_we          out  1        write beat
//  mem_address     out  ADDR_W   beat address, aligned to XLEN/8
//  mem_write_data  out  XLEN     byte-lane-positioned store data
//  mem_byte_enable out  XLEN/8   active byte lanes
//  mem_rvalid      in   1        beat response (loads and stores)
//  mem_read_data   in   XLEN     read data, valid with mem_rvalid
//  mem_error       in   1        bus error, valid with mem_rvalid
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, every other output 0, captured request cleared.
//  - FSM: IDLE -> ISSUE0 -> WAIT0 -> [ISSUE1 -> WAIT1] -> RESPOND -> IDLE.
//  - Accept on req_valid&&req_ready; latch all req_* fields. off=addr[log2(XLEN/8)-1:0];
//    bytes=1<<size; cross=(off+bytes > XLEN/8).
//  - Illegal size, or cross with ALLOW_MISALIGNED=0: IDLE->RESPOND with no bus activity;
//    resp_valid/resp_error=1 the cycle after accept.
//  - ISSUE: mem_req=1; address/we/data/byte_enable stable until mem_gnt (gnt in the first
//    ISSUE cycle allowed) -> WAIT. One outstanding beat only. mem_rvalid outside WAIT ignored.
//  - WAIT: on mem_rvalid, capture data. If mem_error, or beat complete, -> RESPOND; else ISSUE1.
//    Error on beat 0 of a split access cancels beat 1.
//  - Beat 0 address = addr & ~(XLEN/8-1). Beat 1 = beat 0 + XLEN/8, wraps mod 2^ADDR_WIDTH.
//  - Store: beat-0 data = wdata << 8*off, be = bytemask << off (truncated to XLEN/8);
//    beat 1 gets the spilled upper bytes/lanes at lane 0.
//  - Load: merge beat bytes, shift right by 8*off, extend from 8*bytes bits per req_unsigned.
//  - RESPOND: resp_valid=1 for exactly one cycle; error -> resp_data=0.
//  - Min latency, aligned, gnt immediate, rvalid next cycle: accept c0, mem_req c1,
//    rvalid c2, resp_valid c3. Split access adds 2 cycles.
//  - Reset mid-op: FSM back to IDLE at once; mem_req/resp_valid drop asynchronously.
//    Late rvalid after release ignored.
// STRUCTURE
//  - Package lsu_pkg: access_size_t enum (SIZE_BYTE..SIZE_DWORD), lsu_state_t enum,
//    function size_bytes(access_size_t).
//  - Sub-module lsu_align: combinational lane shift, byte-enable generation,
//    load extract/extend. FSM and capture registers stay in load_store_unit.
// TESTING
//  1 XLEN=32 LW 0x100, gnt c1, rvalid c2 data 0xDEADBEEF -> one beat, be=4'b1111,
//    resp_valid c3, data 0xDEADBEEF.
//  2 LB 0x103, read 0x80000000 -> 0xFFFFFF80; LBU same -> 0x00000080; be=4'b1000.
//  3 SW 0x0FE data 0x11223344 -> beat0 addr 0x0FC be 1100 wdata 0x33440000;
//    beat1 addr 0x100 be 0011 wdata 0x00001122; resp_error=0.
//  4 ALLOW_MISALIGNED=0, LW 0x0FE -> mem_req never high, resp_valid+resp_error c1;
//    XLEN=32 req_size=3 -> same.
//  5 mem_gnt withheld 5 cycles -> mem_req/address/be stable; split LW 0x0FE, mem_error on
//    beat0 -> no beat1, resp_error=1, resp_data=0.
//  6 reset low in WAIT0 -> mem_req=0, req_ready=1 immediately; rvalid after release ignored.
//    XLEN=64 LD 0xFFFF_FFFC -> beat1 addr wraps to 0x0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and
// a size-to-byte-count helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } access_size_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE0,
    ST_WAIT0,
    ST_ISSUE1,
    ST_WAIT1,
    ST_RESPOND
  } lsu_state_t;

  function automatic logic [3:0] size_bytes(access_size_t s);
    return 4'd1 << s;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store data / byte-enable placement across two
// beats, and load extraction with sign/zero extension from two merged beats.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off,
  input  access_size_t              size,
  input  logic                      is_unsigned,
  input  logic [XLEN-1:0]           wdata,
  output logic [XLEN-1:0]           wdata0,
  output logic [XLEN-1:0]           wdata1,
  output logic [XLEN/8-1:0]         be0,
  output logic [XLEN/8-1:0]         be1,
  input  logic [XLEN-1:0]           rdata0,
  input  logic [XLEN-1:0]           rdata1,
  output logic [XLEN-1:0]           load_data
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [OFFW+2:0]   sh;
  logic [2*XLEN-1:0] wide_w;
  logic [2*NB-1:0]   mask;
  logic [2*NB-1:0]   wide_be;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ext_mask;
  logic              sign_bit;

  assign sh = {off, 3'b000};

  // Double-width shift: the upper half is whatever spills into the next beat.
  assign wide_w           = {{XLEN{1'b0}}, wdata} << sh;
  assign {wdata1, wdata0} = wide_w;
  assign wide_be          = mask << off;
  assign be0              = wide_be[NB-1:0];
  assign be1              = wide_be[2*NB-1:NB];

  assign shifted = XLEN'({rdata1, rdata0} >> sh);

  always_comb begin
    mask     = (2*NB)'(8'hFF);
    ext_mask = '1;
    sign_bit = 1'b0;
    case (size)
      SIZE_BYTE: begin
        mask     = (2*NB)'(8'h01);
        ext_mask = XLEN'(32'h0000_00FF);
        sign_bit = shifted[7];
      end
      SIZE_HALF: begin
        mask     = (2*NB)'(8'h03);
        ext_mask = XLEN'(32'h0000_FFFF);
        sign_bit = shifted[15];
      end
      SIZE_WORD: begin
        mask     = (2*NB)'(8'h0F);
        ext_mask = XLEN'(32'hFFFF_FFFF);
        sign_bit = shifted[31];
      end
      default: ;
    endcase
  end

  assign load_data = (shifted & ext_mask) | ((sign_bit && !is_unsigned) ? ~ext_mask : '0);

endmodule

// File: rtl/load_store_unit.sv
// Load/store engine: accepts one core request, drives one or two bus beats
// (split at an XLEN boundary) and returns extended load data or a store ack.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_address,
  input  logic [XLEN-1:0]       req_write_data,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_data,
  output logic                  resp_error,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [XLEN-1:0]       mem_write_data,
  output logic [XLEN/8-1:0]     mem_byte_enable,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_read_data,
  input  logic                  mem_error
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_t            state_q, state_d;
  logic                  store_q, store_d;
  access_size_t          size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       rdata0_q, rdata0_d;
  logic [XLEN-1:0]       rdata1_q, rdata1_d;
  logic                  split_q, split_d;
  logic                  err_q, err_d;
  logic                  req_ready_q, req_ready_d;
  logic                  mem_req_q, mem_req_d;
  logic                  beat1_q, beat1_d;
  logic                  resp_valid_q, resp_valid_d;

  access_size_t          in_size;
  logic [4:0]            in_span;
  logic                  in_cross, in_illegal;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [XLEN-1:0]       st_w0, st_w1, load_data;
  logic [NB-1:0]         be0, be1;

  assign in_size    = access_size_t'(req_size);
  assign in_span    = 5'(req_address[OFFW-1:0]) + 5'(size_bytes(in_size));
  assign in_cross   = in_span > 5'(NB);
  assign in_illegal = (in_size == SIZE_DWORD) && (XLEN < 64);

  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    split_d  = split_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: if (req_valid && req_ready_q) begin
        store_d  = req_store;
        size_d   = in_size;
        uns_d    = req_unsigned;
        addr_d   = req_address;
        wdata_d  = req_write_data;
        rdata0_d = '0;
        rdata1_d = '0;
        split_d  = in_cross;
        err_d    = 1'b0;
        // Rejected requests never touch the bus.
        if (in_illegal || (in_cross && !ALLOW_MISALIGNED)) begin
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          state_d = ST_ISSUE0;
        end
      end
      ST_ISSUE0: if (mem_gnt) state_d = ST_WAIT0;
      ST_WAIT0: if (mem_rvalid) begin
        rdata0_d = mem_read_data;
        if (mem_error) begin
          err_d   = 1'b1;
          state_d = ST_RESPOND;
        end else begin
          state_d = split_q ? ST_ISSUE1 : ST_RESPOND;
        end
      end
      ST_ISSUE1: if (mem_gnt) state_d = ST_WAIT1;
      ST_WAIT1: if (mem_rvalid) begin
        rdata1_d = mem_read_data;
        err_d    = mem_error;
        state_d  = ST_RESPOND;
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    req_ready_d  = (state_d == ST_IDLE);
    mem_req_d    = (state_d == ST_ISSUE0) || (state_d == ST_ISSUE1);
    beat1_d      = (state_d == ST_ISSUE1);
    resp_valid_d = (state_d == ST_RESPOND);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      store_q      <= 1'b0;
      size_q       <= SIZE_BYTE;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      split_q      <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_req_q    <= 1'b0;
      beat1_q      <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      split_q      <= split_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      mem_req_q    <= mem_req_d;
      beat1_q      <= beat1_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .off         (addr_q[OFFW-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .wdata0      (st_w0),
    .wdata1      (st_w1),
    .be0         (be0),
    .be1         (be1),
    .rdata0      (rdata0_q),
    .rdata1      (rdata1_q),
    .load_data   (load_data)
  );

  // Beat 1 address wraps naturally at ADDR_WIDTH.
  assign base_addr = {addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};

  assign req_ready       = req_ready_q;
  assign mem_req         = mem_req_q;
  assign mem_we          = mem_req_q & store_q;
  assign mem_address     = mem_req_q ? (beat1_q ? base_addr + ADDR_WIDTH'(NB) : base_addr) : '0;
  assign mem_write_data  = (mem_req_q && store_q) ? (beat1_q ? st_w1 : st_w0) : '0;
  assign mem_byte_enable = mem_req_q ? (beat1_q ? be1 : be0) : '0;
  assign resp_valid      = resp_valid_q;
  assign resp_error      = resp_valid_q & err_q;
  assign resp_data       = (resp_valid_q && !store_q && !err_q) ? load_data : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: stimulus queues expected beats/responses, a bus responder
// and a response monitor pop and compare independently.
module tb_load_store_unit;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int gnt_delay = 0;
  int inj_req = 0;

  beat_t exp_beat[$];
  rsp_t  exp_resp[$];
  rsp_t  rd_q[$];

  // DUT0: XLEN=32, misaligned allowed
  logic        req_valid, req_ready, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_write_data;
  logic        resp_valid, resp_error;
  logic [31:0] resp_data;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_error;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic [3:0]  mem_byte_enable;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_address(req_address), .req_write_data(req_write_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
    .mem_rvalid(mem_rvalid), .mem_read_data(mem_read_data), .mem_error(mem_error)
  );

  // DUT1: XLEN=32, misaligned rejected; bus never answers
  logic        req_valid_b, req_ready_b, req_store_b, req_unsigned_b;
  logic [1:0]  req_size_b;
  logic [31:0] req_address_b, req_write_data_b;
  logic        resp_valid_b, resp_error_b;
  logic [31:0] resp_data_b;
  logic        mem_req_b, mem_gnt_b, mem_we_b, mem_rvalid_b, mem_error_b;
  logic [31:0] mem_address_b, mem_write_data_b, mem_read_data_b;
  logic [3:0]  mem_byte_enable_b;

  load_store_unit #(.XLEN(32), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_store(req_store_b), .req_size(req_size_b),
    .req_unsigned(req_unsigned_b), .req_address(req_address_b), .req_write_data(req_write_data_b),
    .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_error(resp_error_b),
    .mem_req(mem_req_b), .mem_gnt(mem_gnt_b), .mem_we(mem_we_b), .mem_address(mem_address_b),
    .mem_write_data(mem_write_data_b), .mem_byte_enable(mem_byte_enable_b),
    .mem_rvalid(mem_rvalid_b), .mem_read_data(mem_read_data_b), .mem_error(mem_error_b)
  );

  // DUT2: XLEN=64
  logic        req_valid_w, req_ready_w, req_store_w, req_unsigned_w;
  logic [1:0]  req_size_w;
  logic [31:0] req_address_w;
  logic [63:0] req_write_data_w;
  logic        resp_valid_w, resp_error_w;
  logic [63:0] resp_data_w;
  logic        mem_req_w, mem_gnt_w, mem_we_w, mem_rvalid_w, mem_error_w;
  logic [31:0] mem_address_w;
  logic [63:0] mem_write_data_w, mem_read_data_w;
  logic [7:0]  mem_byte_enable_w;

  load_store_unit #(.XLEN(64), .ADDR_WIDTH(32), .ALLOW_MISALIGNED(1'b1)) dut_w (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_store(req_store_w), .req_size(req_size_w),
    .req_unsigned(req_unsigned_w), .req_address(req_address_w), .req_write_data(req_write_data_w),
    .resp_valid(resp_valid_w), .resp_data(resp_data_w), .resp_error(resp_error_w),
    .mem_req(mem_req_w), .mem_gnt(mem_gnt_w), .mem_we(mem_we_w), .mem_address(mem_address_w),
    .mem_write_data(mem_write_data_w), .mem_byte_enable(mem_byte_enable_w),
    .mem_rvalid(mem_rvalid_w), .mem_read_data(mem_read_data_w), .mem_error(mem_error_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  task automatic exp_b(input logic [31:0] a, input logic [3:0] be, input logic we, input logic [31:0] wd);
    beat_t b;
    b.addr = a; b.be = be; b.we = we; b.wdata = wd;
    exp_beat.push_back(b);
  endtask

  task automatic exp_r(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d; r.err = e;
    exp_resp.push_back(r);
  endtask

  task automatic rd(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d; r.err = e;
    rd_q.push_back(r);
  endtask

  // Bus responder for DUT0: grant after gnt_delay cycles, read response next cycle.
  initial begin : responder
    int    wait_cnt;
    int    inj_seen;
    bit    rsp_pend;
    beat_t snap, e;
    rsp_t  r;
    wait_cnt = 0; inj_seen = 0; rsp_pend = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_error = 0; mem_read_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_gnt = 0; mem_rvalid = 0; mem_error = 0; mem_read_data = '0;
      if (rsp_pend || inj_req != inj_seen) begin
        mem_rvalid = 1;
        mem_read_data = 32'hBAD0_BAD0;
        if (rsp_pend && rd_q.size() > 0) begin
          r = rd_q.pop_front();
          mem_read_data = r.data;
          mem_error = r.err;
        end
        rsp_pend = 0;
        inj_seen = inj_req;
      end
      if (!mem_req) wait_cnt = 0;
      else begin
        if (wait_cnt == 0) begin
          snap.addr = mem_address; snap.be = mem_byte_enable;
          snap.we = mem_we; snap.wdata = mem_write_data;
        end else begin
          chk("hold_addr", mem_address, snap.addr);
          chk("hold_be", mem_byte_enable, snap.be);
          chk("hold_wdata", mem_write_data, snap.wdata);
        end
        if (wait_cnt >= gnt_delay) begin
          mem_gnt = 1; rsp_pend = 1; wait_cnt = 0;
          if (exp_beat.size() == 0) fail_now("unexpected_beat", mem_address);
          else begin
            e = exp_beat.pop_front();
            chk("beat_addr", mem_address, e.addr);
            chk("beat_be", mem_byte_enable, e.be);
            chk("beat_we", mem_we, e.we);
            if (e.we) chk("beat_wdata", mem_write_data, e.wdata);
          end
        end else wait_cnt++;
      end
    end
  end

  // Response monitor for DUT0.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_resp.size() == 0) fail_now("unexpected_resp", resp_data);
        else begin
          e = exp_resp.pop_front();
          chk("resp_data", resp_data, e.data);
          chk("resp_error", resp_error, e.err);
        end
      end
    end
  end

  task automatic do_req(input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd, input int lat);
    int cyc;
    cyc = 0;
    @(posedge clk); #1;
    while (!req_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
    chk("req_ready", req_ready, 1);
    req_valid = 1; req_store = st; req_size = sz; req_unsigned = uns;
    req_address = a; req_write_data = wd;
    @(posedge clk); #1;
    req_valid = 0;
    cyc = 1;
    while (!resp_valid && cyc < 60) begin @(posedge clk); #1; cyc++; end
    chk("resp_seen", resp_valid, 1);
    chk("latency", cyc, lat);
  endtask

  task automatic rej_b(input logic [1:0] sz, input logic [31:0] a);
    @(posedge clk); #1;
    req_valid_b = 1; req_size_b = sz; req_address_b = a;
    @(posedge clk); #1;
    req_valid_b = 0;
    chk("rej_resp_valid", resp_valid_b, 1);
    chk("rej_resp_error", resp_error_b, 1);
    chk("rej_resp_data", resp_data_b, 0);
    chk("rej_mem_req", mem_req_b, 0);
    chk("rej_mem_bus", {mem_we_b, mem_byte_enable_b, mem_address_b, mem_write_data_b}, 0);
    @(posedge clk); #1;
    chk("rej_pulse", resp_valid_b, 0);
    chk("rej_ready", req_ready_b, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    reset = 0;
    req_valid = 0; req_store = 0; req_size = 0; req_unsigned = 0; req_address = 0; req_write_data = 0;
    req_valid_b = 0; req_store_b = 0; req_size_b = 0; req_unsigned_b = 0; req_address_b = 0; req_write_data_b = 0;
    mem_gnt_b = 0; mem_rvalid_b = 0; mem_error_b = 0; mem_read_data_b = 0;
    req_valid_w = 0; req_store_w = 0; req_size_w = 0; req_unsigned_w = 0; req_address_w = 0; req_write_data_w = 0;
    mem_gnt_w = 0; mem_rvalid_w = 0; mem_error_w = 0; mem_read_data_w = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_resp", {resp_valid, resp_error, resp_data}, 0);
    chk("rst_bus", {mem_we, mem_byte_enable, mem_address, mem_write_data}, 0);
    chk("rst_ready_w", req_ready_w, 1);
    @(negedge clk); reset = 1;

    // aligned LW
    exp_b(32'h100, 4'b1111, 0, 0); rd(32'hDEADBEEF, 0); exp_r(32'hDEADBEEF, 0);
    do_req(0, 2'd2, 0, 32'h100, 0, 3);
    // LB / LBU at lane 3
    exp_b(32'h100, 4'b1000, 0, 0); rd(32'h80000000, 0); exp_r(32'hFFFFFF80, 0);
    do_req(0, 2'd0, 0, 32'h103, 0, 3);
    exp_b(32'h100, 4'b1000, 0, 0); rd(32'h80000000, 0); exp_r(32'h00000080, 0);
    do_req(0, 2'd0, 1, 32'h103, 0, 3);
    // split SW
    exp_b(32'h0FC, 4'b1100, 1, 32'h33440000); exp_b(32'h100, 4'b0011, 1, 32'h00001122);
    rd(0, 0); rd(0, 0); exp_r(0, 0);
    do_req(1, 2'd2, 0, 32'h0FE, 32'h11223344, 5);
    // split LW merge
    exp_b(32'h0FC, 4'b1100, 0, 0); exp_b(32'h100, 4'b0011, 0, 0);
    rd(32'hAABBCCDD, 0); rd(32'h11223344, 0); exp_r(32'h3344AABB, 0);
    do_req(0, 2'd2, 0, 32'h0FE, 0, 5);
    // SB, split SH, split LHU
    exp_b(32'h100, 4'b0010, 1, 32'h0000A500); rd(0, 0); exp_r(0, 0);
    do_req(1, 2'd0, 0, 32'h101, 32'h000000A5, 3);
    exp_b(32'h0FC, 4'b1000, 1, 32'hEF000000); exp_b(32'h100, 4'b0001, 1, 32'h000000BE);
    rd(0, 0); rd(0, 0); exp_r(0, 0);
    do_req(1, 2'd1, 0, 32'h0FF, 32'h0000BEEF, 5);
    exp_b(32'h0FC, 4'b1000, 0, 0); exp_b(32'h100, 4'b0001, 0, 0);
    rd(32'hAB000000, 0); rd(32'h000000CD, 0); exp_r(32'h0000CDAB, 0);
    do_req(0, 2'd1, 1, 32'h0FF, 0, 5);
    // grant withheld 5 cycles, signed LH
    gnt_delay = 5;
    exp_b(32'h100, 4'b1100, 0, 0); rd(32'h80010000, 0); exp_r(32'hFFFF8001, 0);
    do_req(0, 2'd1, 0, 32'h102, 0, 8);
    gnt_delay = 0;
    // error on beat 0 cancels beat 1; error on beat 1
    exp_b(32'h0FC, 4'b1100, 0, 0); rd(32'h12345678, 1); exp_r(0, 1);
    do_req(0, 2'd2, 0, 32'h0FE, 0, 3);
    exp_b(32'h0FC, 4'b1100, 0, 0); exp_b(32'h100, 4'b0011, 0, 0);
    rd(32'hAABBCCDD, 0); rd(32'h11223344, 1); exp_r(0, 1);
    do_req(0, 2'd2, 0, 32'h0FE, 0, 5);
    // dword on XLEN=32 is illegal
    exp_r(0, 1);
    do_req(0, 2'd3, 0, 32'h100, 0, 1);

    // rejections on the no-misalign instance
    rej_b(2'd2, 32'h0FE);
    rej_b(2'd3, 32'h100);

    // XLEN=64 LD wrapping past the top of the address space
    @(posedge clk); #1;
    req_valid_w = 1; req_size_w = 2'd3; req_address_w = 32'hFFFF_FFFC;
    @(posedge clk); #1;
    req_valid_w = 0;
    chk("w_b0_req", mem_req_w, 1);
    chk("w_b0_addr", mem_address_w, 32'hFFFF_FFF8);
    chk("w_b0_be", mem_byte_enable_w, 8'hF0);
    chk("w_b0_we", mem_we_w, 0);
    mem_gnt_w = 1;
    @(posedge clk); #1;
    mem_gnt_w = 0; mem_rvalid_w = 1; mem_read_data_w = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    mem_rvalid_w = 0;
    chk("w_b1_req", mem_req_w, 1);
    chk("w_b1_addr", mem_address_w, 32'h0);
    chk("w_b1_be", mem_byte_enable_w, 8'h0F);
    mem_gnt_w = 1;
    @(posedge clk); #1;
    mem_gnt_w = 0; mem_rvalid_w = 1; mem_read_data_w = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    mem_rvalid_w = 0;
    chk("w_resp_valid", resp_valid_w, 1);
    chk("w_resp_data", resp_data_w, 64'h7777_8888_1111_2222);
    chk("w_resp_error", resp_error_w, 0);
    chk("w_bus_idle", {mem_write_data_w, mem_req_w}, 0);

    // reset while in WAIT0; a late rvalid afterwards must be ignored
    exp_b(32'h100, 4'b1111, 0, 0); rd(32'h12345678, 0);
    @(posedge clk); #1;
    req_valid = 1; req_store = 0; req_size = 2'd2; req_unsigned = 0; req_address = 32'h100;
    @(posedge clk); #1;
    req_valid = 0;
    @(posedge clk); #2;
    chk("wait0_ready", req_ready, 0);
    reset = 0;
    #1;
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_resp", resp_valid, 0);
    @(negedge clk); @(negedge clk); reset = 1;
    inj_req++;
    repeat (6) @(posedge clk); #1;
    chk("post_rst_ready", req_ready, 1);

    // DUT still functional after reset
    exp_b(32'h200, 4'b1111, 0, 0); rd(32'hCAFEF00D, 0); exp_r(32'hCAFEF00D, 0);
    do_req(0, 2'd2, 0, 32'h200, 0, 3);

    repeat (3) @(posedge clk); #1;
    chk("left_beats", exp_beat.size(), 0);
    chk("left_resps", exp_resp.size(), 0);
    chk("left_reads", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
